// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between fetch and data stages with anti-starvation
module mem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              mem_req,
    input  logic [3:0]        mem_wen,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [31:0]       mem_rdata,
    input  logic              cancel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_wen,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    typedef enum logic [1:0] {IDLE, RESP_IF, RESP_MEM} owner_t;
    owner_t            resp_owner, resp_next;
    logic [3:0]        wait_cnt, wait_next;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              cancel_d, starve;
    logic              unused_bits;
    assign unused_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], mem_addr[31:ADDR_W+2], mem_addr[1:0]};
    // Grant selection, RAM drive, response and starvation next-state
    always_comb begin
        starve     = wait_cnt == 4'(MAX_WAIT);
        if_gnt     = ~reset & ~cancel & if_req & (~mem_req | starve);
        mem_gnt    = ~reset & mem_req & ~if_gnt;
        ram_addr   = if_gnt ? if_addr[ADDR_W+1:2] : mem_gnt ? mem_addr[ADDR_W+1:2] : ram_addr_q;
        ram_wen    = mem_gnt ? mem_wen : 4'b0;
        ram_wdata  = mem_wdata;
        resp_next  = if_gnt ? RESP_IF : (mem_gnt && mem_wen == 4'b0) ? RESP_MEM : IDLE;
        wait_next  = (if_gnt || cancel) ? 4'd0 : (if_req && !starve) ? wait_cnt + 4'd1 : wait_cnt;
        if_rvalid  = ~reset & (resp_owner == RESP_IF) & ~cancel_d;
        mem_rvalid = ~reset & (resp_owner == RESP_MEM);
        if_rdata   = ram_rdata;
        mem_rdata  = ram_rdata;
    end
    // State registers: response owner, wait counter, held address, cancel at grant edge
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_owner <= IDLE;
            wait_cnt   <= 4'd0;
            ram_addr_q <= '0;
            cancel_d   <= 1'b0;
        end else begin
            resp_owner <= resp_next;
            wait_cnt   <= wait_next;
            ram_addr_q <= ram_addr;
            cancel_d   <= cancel;
        end
    end
endmodule
